id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath word width.
REQ-002 Parameter CNT_W, default 16, stall performance counter width.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 flush_i  in  1  branch-taken flush of the instruction currently in ID.
REQ-006 ctrl_i  in  10  decoded ID controls {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, ALUOp[2:0], RegDst}.
REQ-007 rs_data_i, rt_data_i, imm_i, pc4_i  in  DATA_W each  register-file reads, sign-extended immediate, PC+4.
REQ-008 rs_i, rt_i, rd_i  in  5 each  ID-stage register numbers.
REQ-009 ctrl_o  out  10  registered controls, same bit order as ctrl_i.
REQ-010 rs_data_o, rt_data_o, imm_o, pc4_o  out  DATA_W each  registered data.
REQ-011 rs_o, rt_o, rd_o  out  5 each  registered register numbers; these feed forwarding RS/RT compare and EX destination select.
REQ-012 valid_o  out  1  EX-stage slot holds a real instruction.
REQ-013 stall_o  out  1  combinational; hold PC and IF/ID register this cycle.
REQ-014 stall_cnt_o  out  CNT_W  count of stall cycles since reset.

Function
REQ-015 hazard = valid_o & ctrl_o.MemRead & (rt_o != 0) & (rt_o == rs_i | rt_o == rt_i).
REQ-016 stall_o SHALL equal hazard & ~flush_i; flush suppresses stall (wrong-path instruction needs no wait).
REQ-017 Capture: if ~flush_i & ~stall_o, all outputs load from inputs at next edge and valid_o becomes 1.
REQ-018 Bubble: if flush_i or stall_o, next edge ctrl_o=0, rs_o=rt_o=rd_o=0, valid_o=0; data outputs load 0.
REQ-019 Bubble register numbers are 0 so downstream forwarding never matches a bubble.
REQ-020 A load-use stall SHALL last exactly one cycle: the inserted bubble has MemRead=0, so hazard deasserts next cycle.
REQ-021 Back-to-back loads: second load's dependence is detected against the second load once it reaches EX; no combined multi-cycle stall.
REQ-022 Latency: ID inputs visible on outputs one cycle after capture; no combinational path from ID inputs to any output except stall_o.
REQ-023 stall_cnt_o increments by 1 on each edge where stall_o=1, saturating at all-ones (no wrap).
REQ-024 rs_i/rt_i == 0 never causes a stall (guaranteed by rt_o != 0 term).

Reset
REQ-025 On rst_i=1 at an edge: all registered outputs 0, valid_o=0, stall_cnt_o=0; rst_i has priority over flush_i and stall.
REQ-026 During reset cycle stall_o evaluates from reset state (valid_o=0) and is therefore 0 from the cycle after reset onward until a load enters.

Structure
REQ-027 Shared package holds: control-vector width (10), bit index constants for each control field, ALUOp encodings, register-number width (5).
REQ-028 One sub-module, load_use_detect, purely combinational, computing hazard from rt_o, ctrl_o.MemRead, valid_o, rs_i, rt_i.
REQ-029 All state in one clocked process; no latches, no asynchronous logic.

Verification
REQ-030 lw $8 in EX (MemRead=1, rt_o=8, valid_o=1), ID rs_i=8 -> stall_o=1; next cycle ctrl_o=0, valid_o=0, stall_cnt_o=1; following cycle stall_o=0.
REQ-031 Same load, ID rt_i=8, flush_i=1 -> stall_o=0, bubble inserted, stall_cnt_o unchanged.
REQ-032 lw $0 in EX, ID rs_i=0 -> stall_o=0, ID instruction captured with valid_o=1.
REQ-033 add with rs_i=3, rt_i=4, rd_i=5, rs_data_i=32'h11, ctrl_i RegWrite=1 -> one cycle later rs_o=3, rt_o=4, rd_o=5, rs_data_o=32'h11, valid_o=1.
REQ-034 Force stall_cnt_o to all-ones via CNT_W=2 build and four stalls -> value stays 2'b11.
REQ-035 rst_i=1 asserted mid-stall with flush_i=1 -> next edge all outputs 0, stall_cnt_o=0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-vector layout,
// ALUOp encodings and register-number width.
package id_ex_stage_pkg;
    localparam int CTRL_W = 10;
    localparam int REG_W  = 5;

    // ctrl = {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, ALUOp[2:0], RegDst}
    localparam int CTRL_REGWRITE = 9;
    localparam int CTRL_MEMTOREG = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_ALUOP_HI = 3;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_REGDST   = 0;

    localparam logic [2:0] ALUOP_ADD   = 3'd0;
    localparam logic [2:0] ALUOP_SUB   = 3'd1;
    localparam logic [2:0] ALUOP_RTYPE = 3'd2;
    localparam logic [2:0] ALUOP_AND   = 3'd3;
    localparam logic [2:0] ALUOP_OR    = 3'd4;
    localparam logic [2:0] ALUOP_SLT   = 3'd5;

    function automatic logic [2:0] alu_op(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
    endfunction
endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard check: a load in EX whose destination is
// read by the instruction currently in ID.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_mem_read,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hazard
);
    // $0 is hardwired, so a load targeting it never creates a dependence
    assign hazard = ex_valid & ex_mem_read & (ex_rt != '0) &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion
// on stall/flush, and a saturating stall-cycle counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] pc4_i,
    input  logic [REG_W-1:0]  rs_i,
    input  logic [REG_W-1:0]  rt_i,
    input  logic [REG_W-1:0]  rd_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [DATA_W-1:0] pc4_o,
    output logic [REG_W-1:0]  rs_o,
    output logic [REG_W-1:0]  rt_o,
    output logic [REG_W-1:0]  rd_o,
    output logic              valid_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    logic hazard;

    load_use_detect u_load_use_detect (
        .ex_rt       (rt_o),
        .ex_mem_read (ctrl_o[CTRL_MEMREAD]),
        .ex_valid    (valid_o),
        .id_rs       (rs_i),
        .id_rt       (rt_i),
        .hazard      (hazard)
    );

    // A flushed ID instruction is discarded anyway, so it never waits
    assign stall_o = hazard & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_o      <= '0;
            rs_data_o   <= '0;
            rt_data_o   <= '0;
            imm_o       <= '0;
            pc4_o       <= '0;
            rs_o        <= '0;
            rt_o        <= '0;
            rd_o        <= '0;
            valid_o     <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if (flush_i || stall_o) begin
                // Zero register numbers keep forwarding from matching a bubble
                ctrl_o    <= '0;
                rs_data_o <= '0;
                rt_data_o <= '0;
                imm_o     <= '0;
                pc4_o     <= '0;
                rs_o      <= '0;
                rt_o      <= '0;
                rd_o      <= '0;
                valid_o   <= 1'b0;
            end else begin
                ctrl_o    <= ctrl_i;
                rs_data_o <= rs_data_i;
                rt_data_o <= rt_data_i;
                imm_o     <= imm_i;
                pc4_o     <= pc4_i;
                rs_o      <= rs_i;
                rt_o      <= rt_i;
                rd_o      <= rd_i;
                valid_o   <= 1'b1;
            end
            if (stall_o && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver pushes expected stall and
// registered-output values from an EX-slot reference model; monitors compare.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst, flush;
    logic [CTRL_W-1:0] ctrl_in;
    logic [DATA_W-1:0] rsd_in, rtd_in, imm_in, pc4_in;
    logic [REG_W-1:0]  rs_in, rt_in, rd_in;
    logic [CTRL_W-1:0] ctrl_out;
    logic [DATA_W-1:0] rsd_out, rtd_out, imm_out, pc4_out;
    logic [REG_W-1:0]  rs_out, rt_out, rd_out;
    logic              valid_out, stall_out;
    logic [CNT_W-1:0]  cnt_out;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .ctrl_i(ctrl_in),
        .rs_data_i(rsd_in), .rt_data_i(rtd_in), .imm_i(imm_in), .pc4_i(pc4_in),
        .rs_i(rs_in), .rt_i(rt_in), .rd_i(rd_in),
        .ctrl_o(ctrl_out), .rs_data_o(rsd_out), .rt_data_o(rtd_out),
        .imm_o(imm_out), .pc4_o(pc4_out), .rs_o(rs_out), .rt_o(rt_out),
        .rd_o(rd_out), .valid_o(valid_out), .stall_o(stall_out),
        .stall_cnt_o(cnt_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] rsd, rtd, imm, pc4;
        logic [REG_W-1:0]  rs, rt, rd;
        logic              valid;
        int                cnt;
    } slot_t;

    slot_t ex;              // model of what the EX slot holds
    bit    known = 0;
    slot_t out_q[$];
    bit    stall_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    bit    done = 0;

    localparam logic [CTRL_W-1:0] LW_CTRL =
        (10'd1 << CTRL_REGWRITE) | (10'd1 << CTRL_MEMTOREG) |
        (10'd1 << CTRL_MEMREAD)  | (10'd1 << CTRL_ALUSRC);
    localparam logic [CTRL_W-1:0] ADD_CTRL =
        (10'd1 << CTRL_REGWRITE) | (10'(ALUOP_RTYPE) << CTRL_ALUOP_LO) |
        (10'd1 << CTRL_REGDST);

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit f, input logic [CTRL_W-1:0] c,
                         input int s, input int t, input int d,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [DATA_W-1:0] im, input logic [DATA_W-1:0] pc);
        bit dep, st;
        slot_t nx;
        @(negedge clk);
        rst = r; flush = f; ctrl_in = c;
        rs_in = REG_W'(s); rt_in = REG_W'(t); rd_in = REG_W'(d);
        rsd_in = a; rtd_in = b; imm_in = im; pc4_in = pc;
        #1;
        // A valid load writing a nonzero register that ID reads must wait once
        dep = known && ex.valid && ex.ctrl[CTRL_MEMREAD] && ex.rt != 0 &&
              (int'(ex.rt) == s || int'(ex.rt) == t);
        st = dep && !f;
        if (known) stall_q.push_back(st);
        nx = '{ctrl: '0, rsd: '0, rtd: '0, imm: '0, pc4: '0,
               rs: '0, rt: '0, rd: '0, valid: 1'b0, cnt: ex.cnt};
        if (r) begin
            nx.cnt = 0;
        end else begin
            if (!f && !st)
                nx = '{ctrl: c, rsd: a, rtd: b, imm: im, pc4: pc,
                       rs: REG_W'(s), rt: REG_W'(t), rd: REG_W'(d),
                       valid: 1'b1, cnt: ex.cnt};
            if (st && nx.cnt < CNT_MAX) nx.cnt = nx.cnt + 1;
        end
        if (r || known) begin
            ex = nx;
            known = 1;
            out_q.push_back(ex);
        end
    endtask

    task automatic idle(input bit r, input bit f);
        drive(r, f, '0, 0, 0, 0, '0, '0, '0, '0);
    endtask

    // Combinational stall check, mid low phase once inputs have settled
    initial forever begin
        @(negedge clk); #2;
        if (stall_q.size() > 0) chk("stall_o", stall_out, stall_q.pop_front());
    end

    // Registered outputs, just after the edge
    initial forever begin
        slot_t e;
        @(posedge clk); #1;
        if (out_q.size() > 0) begin
            e = out_q.pop_front();
            chk("ctrl_o", ctrl_out, e.ctrl);
            chk("rs_data_o", rsd_out, e.rsd);
            chk("rt_data_o", rtd_out, e.rtd);
            chk("imm_o", imm_out, e.imm);
            chk("pc4_o", pc4_out, e.pc4);
            chk("rs_o", rs_out, e.rs);
            chk("rt_o", rt_out, e.rt);
            chk("rd_o", rd_out, e.rd);
            chk("valid_o", valid_out, e.valid);
            chk("stall_cnt_o", cnt_out, e.cnt);
        end
    end

    initial begin
        rst = 1; flush = 0; ctrl_in = '0; rs_in = '0; rt_in = '0; rd_in = '0;
        rsd_in = '0; rtd_in = '0; imm_in = '0; pc4_in = '0;
        idle(1, 0);
        idle(1, 0);
        // add $5,$3,$4 captured next edge
        drive(0, 0, ADD_CTRL, 3, 4, 5, 32'h11, 32'h22, 32'h0, 32'h104);
        // lw $8 then a dependent reader through rs: one-cycle stall
        drive(0, 0, LW_CTRL, 2, 8, 0, 32'h40, 32'h0, 32'h4, 32'h108);
        drive(0, 0, ADD_CTRL, 8, 1, 9, 32'h5, 32'h6, 32'h0, 32'h10c);
        drive(0, 0, ADD_CTRL, 8, 1, 9, 32'h5, 32'h6, 32'h0, 32'h10c);
        // lw $8 then flushed reader through rt: no stall, bubble
        drive(0, 0, LW_CTRL, 2, 8, 0, 32'h40, 32'h0, 32'h4, 32'h110);
        drive(0, 1, ADD_CTRL, 1, 8, 9, 32'h5, 32'h6, 32'h0, 32'h114);
        // lw $0 with reader of $0: never stalls
        drive(0, 0, LW_CTRL, 2, 0, 0, 32'h40, 32'h0, 32'h4, 32'h118);
        drive(0, 0, ADD_CTRL, 0, 0, 7, 32'h1, 32'h2, 32'h0, 32'h11c);
        // back-to-back dependent loads, enough stalls to saturate the counter
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, LW_CTRL, 6, 8, 0, 32'h80, 32'h0, 32'h8, 32'h200);
            drive(0, 0, LW_CTRL, 8, 8, 0, 32'h84, 32'h0, 32'hc, 32'h204);
            drive(0, 0, LW_CTRL, 8, 8, 0, 32'h84, 32'h0, 32'hc, 32'h204);
        end
        // reset asserted while a stall is pending, with flush also high
        drive(0, 0, LW_CTRL, 2, 8, 0, 32'h40, 32'h0, 32'h4, 32'h300);
        drive(1, 1, ADD_CTRL, 8, 8, 9, 32'h5, 32'h6, 32'h0, 32'h304);
        idle(0, 0);
        // randomized traffic on a small register pool to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic [CTRL_W-1:0] c;
            c = CTRL_W'($urandom);
            c[CTRL_MEMREAD] = ($urandom_range(0, 1) == 1);
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0, c,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31),
                  $urandom, $urandom, $urandom, $urandom);
        end
        idle(0, 0);
        repeat (3) @(negedge clk);
        chk("queues_drained", out_q.size() + stall_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected end before 200000");
        $fatal(1);
    end
endmodule
